// File: rtl/cam_emu_pkg.sv
// Shared types for the camera sensor emulator: FSM states, pattern codes and
// the mapping from a frame line index to the frame-timing state.
package cam_emu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_MOVE  = 2'd3;

  // Timing state that owns line ln of a frame.
  function automatic state_e line_state(input int ln, input int vs, input int vb, input int va);
    if (ln < vs) return VSYNC;
    if (ln < vs + vb) return VBACK;
    if (ln < vs + vb + va) return ACTIVE;
    return VFRONT;
  endfunction

endpackage

// File: rtl/cam_emu_pattern.sv
// Combinational test-pattern generator; the parent registers the result on
// the pixel-clock falling edge.
module cam_emu_pattern
  import cam_emu_pkg::*;
(
  input  logic [1:0] pat_i,
  input  logic [7:0] x_i,
  input  logic [7:0] aln_i,
  input  logic [7:0] fcnt_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = 8'h00;
    case (pat_i)
      PAT_HRAMP: y_o = x_i;
      PAT_VRAMP: y_o = aln_i;
      PAT_CHECK: y_o = {8{x_i[3] ^ aln_i[3]}};
      PAT_MOVE:  y_o = x_i + aln_i + fcnt_i;
      default:   y_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/cam_sensor_emu.sv
// Camera sensor emulator: drives pclk, hsync/vsync frame timing and test-pattern
// pixel data on the 8-bit parallel camera interface.
module cam_sensor_emu
  import cam_emu_pkg::*;
#(
  parameter int H_ACTIVE    = 160,
  parameter int H_BLANK     = 32,
  parameter int V_ACTIVE    = 120,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 4,
  parameter int V_FRONT     = 4,
  parameter int PCLK_DIV    = 4
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        cam_rst_n_i,
  input  logic        cam_enb_i,
  input  logic [1:0]  pattern_i,
  output logic [7:0]  cam_y,
  output logic        cam_pclk,
  output logic        cam_hsync,
  output logic        cam_vsync,
  output logic [15:0] frame_cnt,
  output logic        frame_done,
  output state_e      dbg_state_o
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DW = $clog2(PCLK_DIV);
  localparam int XW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int LW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(PCLK_DIV / 2);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [LW-1:0] L_LAST   = LW'(V_TOTAL - 1);
  localparam logic [LW-1:0] L_ACT    = LW'(VSYNC_LINES + V_BACK);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pclk_q;
  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [LW-1:0] ln_q, ln_d, ln_inc, aln_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    y_q, y_d, pat_y;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          tick, rst;

  // Either the system reset or the capture side's soft reset clears everything.
  assign rst    = !reset_n || !cam_rst_n_i;
  assign tick   = (div_cnt_q == DIV_LAST);
  assign ln_inc = ln_q + LW'(1);
  assign aln_d  = ln_d - L_ACT;

  cam_emu_pattern u_pattern (
    .pat_i  (pat_d),
    .x_i    (8'(x_d)),
    .aln_i  (8'(aln_d)),
    .fcnt_i (frame_cnt_d[7:0]),
    .y_o    (pat_y)
  );

  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + DW'(1);
    state_d      = state_q;
    x_d          = x_q;
    ln_d         = ln_q;
    pat_d        = pat_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (tick) begin
      if (state_q == IDLE) begin
        if (!cam_enb_i) begin
          state_d = VSYNC;
          x_d     = '0;
          ln_d    = '0;
          pat_d   = pattern_i;
        end
      end else if (x_q != X_LAST) begin
        x_d = x_q + XW'(1);
      end else begin
        x_d = '0;
        if (ln_q != L_LAST) begin
          ln_d    = ln_inc;
          state_d = line_state(int'(ln_inc), VSYNC_LINES, V_BACK, V_ACTIVE);
        end else begin
          // Standby is honoured only here, at the frame boundary.
          ln_d         = '0;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          frame_done_d = 1'b1;
          if (cam_enb_i) begin
            state_d = IDLE;
          end else begin
            state_d = VSYNC;
            pat_d   = pattern_i;
          end
        end
      end
    end
  end

  // Interface outputs describe the position being entered and change only on ticks.
  always_comb begin
    vsync_d = vsync_q;
    hsync_d = hsync_q;
    y_d     = y_q;
    if (tick) begin
      vsync_d = (state_d == VSYNC);
      hsync_d = (state_d == ACTIVE) && (int'(x_d) < H_ACTIVE);
      y_d     = hsync_d ? pat_y : 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      div_cnt_q    <= '0;
      pclk_q       <= 1'b0;
      state_q      <= IDLE;
      x_q          <= '0;
      ln_q         <= '0;
      pat_q        <= PAT_HRAMP;
      frame_cnt_q  <= 16'd0;
      frame_done_q <= 1'b0;
      y_q          <= 8'h00;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pclk_q       <= (div_cnt_d >= DIV_HALF);
      state_q      <= state_d;
      x_q          <= x_d;
      ln_q         <= ln_d;
      pat_q        <= pat_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  assign cam_y       = y_q;
  assign cam_pclk    = pclk_q;
  assign cam_hsync   = hsync_q;
  assign cam_vsync   = vsync_q;
  assign frame_cnt   = frame_cnt_q;
  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cam_sensor_emu.sv
// Bench for cam_sensor_emu: random control stimulus against a frame-position
// reference model, plus a queue of pixels expected at pclk rising edges.
module tb_cam_sensor_emu;
  import cam_emu_pkg::*;

  localparam int HA = 16, HB = 2, VA = 10, VS = 2, VB = 1, VF = 1, DIV = 2;
  localparam int HT = HA + HB;
  localparam int LINES = VS + VB + VA + VF;
  localparam int FRAME_TICKS = HT * LINES;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cam_rst_n = 1'b1;
  logic cam_enb = 1'b0;
  logic [1:0] pattern = 2'd0;
  always #5 clk = ~clk;

  logic [7:0]  cam_y;
  logic        cam_pclk, cam_hsync, cam_vsync, frame_done;
  logic [15:0] frame_cnt;
  state_e      dbg_state;

  cam_sensor_emu #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_FRONT(VF), .PCLK_DIV(DIV)
  ) dut (
    .clk_i       (clk),
    .reset_n     (reset_n),
    .cam_rst_n_i (cam_rst_n),
    .cam_enb_i   (cam_enb),
    .pattern_i   (pattern),
    .cam_y       (cam_y),
    .cam_pclk    (cam_pclk),
    .cam_hsync   (cam_hsync),
    .cam_vsync   (cam_vsync),
    .frame_cnt   (frame_cnt),
    .frame_done  (frame_done),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: frame described as a flat tick index into the frame
  bit m_idle = 1'b1;
  bit m_pclk = 1'b0;
  bit m_fdone = 1'b0;
  int m_p = 0;
  int m_pat = 0;
  logic [15:0] m_fcnt = 16'd0;

  function automatic logic [7:0] ref_y(input int pat, input int x, input int aln, input logic [15:0] fc);
    case (pat)
      0: return 8'(x);
      1: return 8'(aln);
      2: return (((x / 8) % 2) != ((aln / 8) % 2)) ? 8'hFF : 8'h00;
      default: return 8'(x + aln + int'(fc[7:0]));
    endcase
  endfunction

  // {vsync, hsync, y} for the pixel at frame tick p
  function automatic logic [9:0] ref_pix(input bit idle, input int p, input int pat, input logic [15:0] fc);
    int line, x;
    bit vs, hs;
    logic [7:0] y;
    if (idle) return 10'd0;
    line = p / HT;
    x    = p % HT;
    vs   = (line < VS);
    hs   = (line >= VS + VB) && (line < VS + VB + VA) && (x < HA);
    y    = hs ? ref_y(pat, x, line - VS - VB, fc) : 8'h00;
    return {vs, hs, y};
  endfunction

  // driver: check outputs at the falling clk edge, drive inputs, advance model
  task automatic cycle(input bit rst_n, input bit crst_n, input bit enb, input logic [1:0] pat);
    logic [9:0] e;
    @(negedge clk);
    e = ref_pix(m_idle, m_p, m_pat, m_fcnt);
    chk("pclk", 32'(cam_pclk), 32'(m_pclk));
    chk("vsync", 32'(cam_vsync), 32'(e[9]));
    chk("hsync", 32'(cam_hsync), 32'(e[8]));
    chk("y", 32'(cam_y), 32'(e[7:0]));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("frame_done", 32'(frame_done), 32'(m_fdone));
    if (cam_pclk && cam_hsync) begin
      chk("pix_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("pix_y", 32'(cam_y), 32'(exp_q.pop_front()));
    end
    reset_n   = rst_n;
    cam_rst_n = crst_n;
    cam_enb   = enb;
    pattern   = pat;
    if (!rst_n || !crst_n) begin
      m_idle = 1'b1; m_p = 0; m_pat = 0; m_pclk = 1'b0; m_fdone = 1'b0; m_fcnt = 16'd0;
      exp_q.delete();
    end else begin
      m_fdone = 1'b0;
      if (m_pclk) begin
        if (m_idle) begin
          if (!enb) begin m_idle = 1'b0; m_p = 0; m_pat = int'(pat); end
        end else if (m_p == FRAME_TICKS - 1) begin
          m_fcnt++;
          m_fdone = 1'b1;
          if (enb) m_idle = 1'b1;
          else begin m_p = 0; m_pat = int'(pat); end
        end else begin
          m_p++;
        end
        e = ref_pix(m_idle, m_p, m_pat, m_fcnt);
        if (e[8]) exp_q.push_back(e[7:0]);
      end
      m_pclk = !m_pclk;
    end
  endtask

  bit r_enb;
  logic [1:0] r_pat;

  initial begin
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0);

    // first frame, horizontal ramp, then a frame whose pattern_i changes mid-frame
    for (int i = 0; i < 2 * FRAME_TICKS + 6; i++) cycle(1'b1, 1'b1, 1'b0, 2'd0);
    chk("first_frame_cnt", 32'(frame_cnt), 32'd1);
    for (int i = 0; i < 2 * FRAME_TICKS; i++)
      cycle(1'b1, 1'b1, 1'b0, (i < FRAME_TICKS) ? 2'd0 : 2'd2);

    // moving ramp over two frames
    for (int i = 0; i < 4 * FRAME_TICKS; i++) cycle(1'b1, 1'b1, 1'b0, 2'd3);

    // random standby, pattern changes, soft resets and one system reset
    r_enb = 1'b0;
    r_pat = 2'd1;
    for (int i = 0; i < 14000; i++) begin
      if (!r_enb && $urandom_range(0, 399) == 0) r_enb = 1'b1;
      else if (r_enb && $urandom_range(0, 99) == 0) r_enb = 1'b0;
      if ($urandom_range(0, 39) == 0) r_pat = 2'($urandom_range(0, 3));
      cycle((i < 7000 || i > 7002) ? 1'b1 : 1'b0, ($urandom_range(0, 2999) != 0), r_enb, r_pat);
    end

    // drain into standby, then wake up again
    for (int i = 0; i < 2 * FRAME_TICKS + 8; i++) cycle(1'b1, 1'b1, 1'b1, 2'd0);
    chk("standby_state", 32'(dbg_state), 32'(IDLE));
    chk("pix_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 2'd1);
    chk("wake_vsync", 32'(cam_vsync), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
